// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encodings, the $zero register index
// and the load-use compare used by the hazard controller.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;

   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_e;

   // True when a load in EX writes a non-$zero register that the ID instruction reads.
   function automatic logic load_use_hit(
      input logic             ex_mem_read,
      input logic [REG_W-1:0] ex_wr_reg,
      input logic [REG_W-1:0] id_rs,
      input logic [REG_W-1:0] id_rt,
      input logic             id_uses_rt
   );
      logic rs_hit;
      logic rt_hit;
      rs_hit = (ex_wr_reg == id_rs);
      rt_hit = id_uses_rt && (ex_wr_reg == id_rt);
      return ex_mem_read && (ex_wr_reg != ZERO_REG) && (rs_hit || rt_hit);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Hold at all ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// branch/jump flushes, data-memory freeze with timeout, and perf counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_uses_rt,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_Write_register,
   input  logic             EX_Branch_taken,
   input  logic             MEM_req,
   input  logic             MEM_ready,
   output logic             PC_wr_en,
   output logic             IF_ID_wr_en,
   output logic             IF_ID_flush,
   output logic             ID_EX_wr_en,
   output logic             ID_EX_flush,
   output logic             EX_MEM_wr_en,
   output logic             MEM_WB_wr_en,
   output logic             mem_err,
   output logic             state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned     WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_e         state_q;
   hz_state_e         state_d;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              err_q;
   logic              err_d;

   logic lu_c;
   logic frz_c;
   logic stall_win_c;
   logic stall_inc_c;
   logic flush_inc_c;

   assign lu_c  = load_use_hit(EX_MemRead, EX_Write_register, ID_rs, ID_rt, ID_uses_rt);
   assign frz_c = !MEM_ready && ((state_q == ST_MEM_WAIT) || MEM_req);

   // Priority: freeze > taken branch > load-use > jump; everything gated off in reset.
   always_comb begin
      PC_wr_en     = 1'b1;
      IF_ID_wr_en  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_wr_en  = 1'b1;
      ID_EX_flush  = 1'b0;
      EX_MEM_wr_en = 1'b1;
      MEM_WB_wr_en = 1'b1;
      stall_win_c  = 1'b0;
      if (!reset) begin
         PC_wr_en     = 1'b0;
         IF_ID_wr_en  = 1'b0;
         ID_EX_wr_en  = 1'b0;
         EX_MEM_wr_en = 1'b0;
         MEM_WB_wr_en = 1'b0;
      end else if (frz_c) begin
         PC_wr_en     = 1'b0;
         IF_ID_wr_en  = 1'b0;
         ID_EX_wr_en  = 1'b0;
         EX_MEM_wr_en = 1'b0;
         MEM_WB_wr_en = 1'b0;
         stall_win_c  = 1'b1;
      end else if (EX_Branch_taken) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (lu_c) begin
         PC_wr_en    = 1'b0;
         IF_ID_wr_en = 1'b0;
         ID_EX_flush = 1'b1;
         stall_win_c = 1'b1;
      end else if (ID_Jump) begin
         IF_ID_flush = 1'b1;
      end
   end

   // Memory-wait FSM with a bounded wait; a timeout sets the sticky error flag.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      unique case (state_q)
         ST_RUN: begin
            if (MEM_req && !MEM_ready) begin
               state_d = ST_MEM_WAIT;
               wait_d  = '0;
            end
         end
         ST_MEM_WAIT: begin
            if (MEM_ready) begin
               state_d = ST_RUN;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_RUN;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   assign stall_inc_c = stall_win_c;
   assign flush_inc_c = IF_ID_flush || ID_EX_flush;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc_c),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc_c),
      .cnt   (flush_cnt)
   );

   assign mem_err = err_q;
   assign state   = 1'(state_q);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the priority logic,
// hand sequences for memory wait, timeout, saturation and reset mid-wait.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CNT_W       = 3;
   localparam int unsigned MEM_TIMEOUT = 4;
   localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

   localparam logic [6:0] C_IDLE  = 7'b1101011;
   localparam logic [6:0] C_LU    = 7'b0001111;
   localparam logic [6:0] C_BR    = 7'b1111111;
   localparam logic [6:0] C_JMP   = 7'b1111011;
   localparam logic [6:0] C_FRZ   = 7'b0000000;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       ID_rs, ID_rt, EX_Write_register;
   logic             ID_uses_rt, ID_Jump, EX_MemRead, EX_Branch_taken, MEM_req, MEM_ready;
   logic             PC_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_wr_en, ID_EX_flush;
   logic             EX_MEM_wr_en, MEM_WB_wr_en, mem_err, state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0]       ctl;

   int total = 0;
   int bad   = 0;
   int unsigned exp_stall = 0;
   int unsigned exp_flush = 0;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       jump;
      logic       memread;
      logic [4:0] wr;
      logic       br;
      logic       req;
      logic       rdy;
      logic [6:0] exp;
      logic       stall;
   } vec_t;

   vec_t tbl [13];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk               (clk),
      .reset             (reset),
      .ID_rs             (ID_rs),
      .ID_rt             (ID_rt),
      .ID_uses_rt        (ID_uses_rt),
      .ID_Jump           (ID_Jump),
      .EX_MemRead        (EX_MemRead),
      .EX_Write_register (EX_Write_register),
      .EX_Branch_taken   (EX_Branch_taken),
      .MEM_req           (MEM_req),
      .MEM_ready         (MEM_ready),
      .PC_wr_en          (PC_wr_en),
      .IF_ID_wr_en       (IF_ID_wr_en),
      .IF_ID_flush       (IF_ID_flush),
      .ID_EX_wr_en       (ID_EX_wr_en),
      .ID_EX_flush       (ID_EX_flush),
      .EX_MEM_wr_en      (EX_MEM_wr_en),
      .MEM_WB_wr_en      (MEM_WB_wr_en),
      .mem_err           (mem_err),
      .state             (state),
      .stall_cnt         (stall_cnt),
      .flush_cnt         (flush_cnt)
   );

   assign ctl = {PC_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_wr_en, ID_EX_flush,
                 EX_MEM_wr_en, MEM_WB_wr_en};

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic jump, input logic memread, input logic [4:0] wr,
                               input logic br, input logic req, input logic rdy,
                               input logic [6:0] exp, input logic stall);
      vec_t v;
      v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.jump = jump; v.memread = memread;
      v.wr = wr; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp; v.stall = stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      ID_rs = v.rs; ID_rt = v.rt; ID_uses_rt = v.uses_rt; ID_Jump = v.jump;
      EX_MemRead = v.memread; EX_Write_register = v.wr; EX_Branch_taken = v.br;
      MEM_req = v.req; MEM_ready = v.rdy;
   endtask

   task automatic quiet();
      drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 1'b0));
   endtask

   task automatic bump(input logic stall, input logic [6:0] exp_ctl);
      if (stall && exp_stall < CNT_MAX) exp_stall++;
      if ((exp_ctl[4] || exp_ctl[2]) && exp_flush < CNT_MAX) exp_flush++;
   endtask

   // One memory-sequence cycle: check controls and state before the edge, state/counters after.
   task automatic mcyc(input string nm, input logic req, input logic rdy, input logic br,
                       input logic [6:0] exp_ctl, input logic st_pre, input logic st_post,
                       input logic err_post);
      MEM_req = req; MEM_ready = rdy; EX_Branch_taken = br;
      #1;
      chk({nm, "_ctl"}, 32'(ctl), 32'(exp_ctl));
      chk({nm, "_state_pre"}, 32'(state), 32'(st_pre));
      bump(exp_ctl == C_FRZ, exp_ctl);
      @(posedge clk); #1;
      chk({nm, "_state_post"}, 32'(state), 32'(st_post));
      chk({nm, "_mem_err"}, 32'(mem_err), 32'(err_post));
      chk({nm, "_stall_cnt"}, 32'(stall_cnt), exp_stall);
      chk({nm, "_flush_cnt"}, 32'(flush_cnt), exp_flush);
   endtask

   initial begin
      tbl[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 1'b0);
      tbl[1]  = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_LU,   1'b1);
      tbl[2]  = mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 1'b0);
      tbl[3]  = mk(5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_LU,   1'b1);
      tbl[4]  = mk(5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_IDLE, 1'b0);
      tbl[5]  = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, C_IDLE, 1'b0);
      tbl[6]  = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, C_BR,   1'b0);
      tbl[7]  = mk(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_JMP,  1'b0);
      tbl[8]  = mk(5'd31, 5'd0, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, C_LU, 1'b1);
      tbl[9]  = mk(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR,   1'b0);
      tbl[10] = mk(5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, C_LU,   1'b1);
      tbl[11] = mk(5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_IDLE, 1'b0);
      tbl[12] = mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_JMP,  1'b0);

      // Reset: controls forced low even with a branch and jump presented.
      reset = 1'b0;
      quiet();
      EX_Branch_taken = 1'b1;
      ID_Jump = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", 32'(ctl), 32'(C_FRZ));
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_mem_err", 32'(mem_err), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      quiet();
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_flush_cnt", 32'(flush_cnt), 32'd0);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(tbl[i].exp));
         bump(tbl[i].stall, tbl[i].exp);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), exp_stall);
         chk($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt), exp_flush);
         chk($sformatf("vec%0d_state", i), 32'(state), 32'd0);
      end
      quiet();

      // Three-cycle memory wait, branch during freeze must not flush.
      mcyc("wait1", 1'b1, 1'b0, 1'b0, C_FRZ,  1'b0, 1'b1, 1'b0);
      mcyc("wait2", 1'b1, 1'b0, 1'b1, C_FRZ,  1'b1, 1'b1, 1'b0);
      mcyc("wait3", 1'b1, 1'b0, 1'b0, C_FRZ,  1'b1, 1'b1, 1'b0);
      mcyc("wait4", 1'b1, 1'b1, 1'b0, C_IDLE, 1'b1, 1'b0, 1'b0);

      // Timeout after the fourth MEM_WAIT cycle; error is sticky.
      mcyc("to1", 1'b1, 1'b0, 1'b0, C_FRZ,  1'b0, 1'b1, 1'b0);
      mcyc("to2", 1'b1, 1'b0, 1'b0, C_FRZ,  1'b1, 1'b1, 1'b0);
      mcyc("to3", 1'b1, 1'b0, 1'b0, C_FRZ,  1'b1, 1'b1, 1'b0);
      mcyc("to4", 1'b1, 1'b0, 1'b0, C_FRZ,  1'b1, 1'b1, 1'b0);
      mcyc("to5", 1'b1, 1'b0, 1'b0, C_FRZ,  1'b1, 1'b0, 1'b1);
      mcyc("to6", 1'b0, 1'b0, 1'b0, C_IDLE, 1'b0, 1'b0, 1'b1);
      mcyc("to7", 1'b0, 1'b1, 1'b0, C_IDLE, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset while in MEM_WAIT.
      mcyc("rw1", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 1'b1, 1'b1);
      #1 reset = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      #1;
      chk("rw_state", 32'(state), 32'd0);
      chk("rw_ctl", 32'(ctl), 32'(C_FRZ));
      chk("rw_mem_err", 32'(mem_err), 32'd0);
      chk("rw_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rw_flush_cnt", 32'(flush_cnt), 32'd0);
      @(posedge clk); #1;
      chk("rw_hold_state", 32'(state), 32'd0);
      chk("rw_hold_ctl", 32'(ctl), 32'(C_FRZ));
      @(negedge clk);
      reset = 1'b1;
      quiet();
      #1;
      chk("rw_rel_ctl", 32'(ctl), 32'(C_IDLE));
      @(posedge clk); #1;
      chk("rw_rel_state", 32'(state), 32'd0);
      chk("rw_rel_stall_cnt", 32'(stall_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
